pe_button_ctrl: RTL and testbench

Memory-mapped input responder for the 5 board push-buttons, on the Bridge's button port.
- Synchronises and debounces each button.
- Exposes live debounced state, sticky press-event flags (write-1-to-clear) and an interrupt mask.
- Raises a level interrupt while any unmasked press is pending.
- Lets software detect individual presses without polling at the clock rate.

---
 rtl/pe_pkg.sv | 18 +
 rtl/pe_button_ctrl_if.sv | 11 +
 rtl/btn_debounce.sv | 45 ++++
 rtl/pe_button_ctrl.sv | 75 +++++++
 tb/tb_pe_button_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared constants for the push-button responder: register offsets,
// reset values and debounce lengths for hardware and simulation builds.
package pe_pkg;

    localparam logic [11:0] BTN_STATE_OFF = 12'h078;
    localparam logic [11:0] BTN_PEND_OFF  = 12'h07C;
    localparam logic [11:0] BTN_MASK_OFF  = 12'h080;

    localparam logic [31:0] BTN_STATE_RST = 32'h0000_0000;
    localparam logic [31:0] BTN_PEND_RST  = 32'h0000_0000;
    localparam logic [31:0] BTN_MASK_RST  = 32'h0000_0000;

    // Roughly 10 ms at 50 MHz on the board; a short window keeps simulations fast.
    localparam int DB_CYCLES_SYN = 500000;
    localparam int DB_CYCLES_SIM = 4;
    localparam int CNT_W_DEF     = 20;

endpackage

// File: rtl/pe_button_ctrl_if.sv
// Bridge-side bus for the button port: zero-wait combinational reads,
// single-cycle write strobes.
interface pe_button_ctrl_if;
    logic [11:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output wen, output wdata, input rdata);
    modport slave  (input addr, input wen, input wdata, output rdata);
endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, persistence counter and the accepted level.
// The rise pulse is high in the cycle before the edge that accepts a 0->1
// change, so a register enabled by it updates on the same edge as the level.
module btn_debounce #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept = (s2 != level) && (cnt == CNT_W'(DB_CYCLES - 1));
    assign rise   = accept && s2;

    // Synchronise, then count consecutive edges where the synchronised input
    // disagrees with the accepted level; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_button_ctrl.sv
// Memory-mapped button responder: debounced live state, sticky W1C press
// flags, interrupt mask and a level interrupt while any unmasked press pends.
module pe_button_ctrl
    import pe_pkg::*;
#(
    parameter int N_BTN     = 5,
    parameter int DB_CYCLES = DB_CYCLES_SYN,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    pe_button_ctrl_if.slave    bus,
    input  logic [N_BTN-1:0]   button,
    output logic               irq
);

    logic [N_BTN-1:0] state;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] pend;
    logic [N_BTN-1:0] mask;
    logic [N_BTN-1:0] clr;
    logic             wr_pend;
    logic             wr_mask;
    logic [31:0]      rd;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (button[i]),
            .level (state[i]),
            .rise  (rise[i])
        );
    end

    assign wr_pend = bus.wen && (bus.addr == BTN_PEND_OFF);
    assign wr_mask = bus.wen && (bus.addr == BTN_MASK_OFF);
    assign clr     = wr_pend ? bus.wdata[N_BTN-1:0] : '0;

    // Press flags: a new press on the same edge as a clear of that bit wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= BTN_PEND_RST[N_BTN-1:0];
        end else begin
            pend <= (pend & ~clr) | rise;
        end
    end

    // Interrupt mask, loaded whole on a store to its offset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask <= BTN_MASK_RST[N_BTN-1:0];
        end else if (wr_mask) begin
            mask <= bus.wdata[N_BTN-1:0];
        end
    end

    // Read mux straight off the registers; unmapped offsets read zero.
    always_comb begin
        rd = '0;
        case (bus.addr)
            BTN_STATE_OFF: rd = 32'(state);
            BTN_PEND_OFF:  rd = 32'(pend);
            BTN_MASK_OFF:  rd = 32'(mask);
            default:       rd = '0;
        endcase
    end

    assign bus.rdata = rd;
    assign irq       = |(pend & mask);

endmodule

// File: tb/tb_pe_button_ctrl.sv
// Self-checking bench for pe_button_ctrl with a short debounce window.
module tb_pe_button_ctrl;
    import pe_pkg::*;

    localparam int N_BTN = 5;

    logic             clk;
    logic             rst;
    logic [N_BTN-1:0] button;
    logic             irq;

    pe_button_ctrl_if bus ();

    pe_button_ctrl #(
        .N_BTN     (N_BTN),
        .DB_CYCLES (DB_CYCLES_SIM),
        .CNT_W     (CNT_W_DEF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .button (button),
        .irq    (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected value is queued when the read is issued and popped once the
    // combinational read data has settled.
    task automatic chk_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        bus.addr = a;
        #1;
        e = exp_q.pop_front();
        chk(tag, bus.rdata, e);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wen   = 1'b1;
        @(posedge clk);
        #1;
        bus.wen   = 1'b0;
        bus.wdata = '0;
    endtask

    initial begin
        rst       = 1'b0;
        button    = 5'h1F;
        bus.addr  = '0;
        bus.wen   = 1'b0;
        bus.wdata = '0;

        // 1. reset with all buttons held
        tick(3);
        chk_rd("rst_state", BTN_STATE_OFF, 32'h0);
        chk_rd("rst_pend",  BTN_PEND_OFF,  32'h0);
        chk_rd("rst_mask",  BTN_MASK_OFF,  32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rst = 1'b1;
        tick(5);
        chk_rd("rel_state_e5", BTN_STATE_OFF, 32'h00);
        tick(1);
        chk_rd("rel_state_e6", BTN_STATE_OFF, 32'h1F);
        chk_rd("rel_pend_e6",  BTN_PEND_OFF,  32'h1F);
        wr(BTN_PEND_OFF, 32'h1F);
        button = '0;
        tick(8);
        chk_rd("released_state", BTN_STATE_OFF, 32'h00);
        chk_rd("released_pend",  BTN_PEND_OFF,  32'h00);

        // 2. clean press of button 2
        button = 5'h04;
        tick(5);
        chk_rd("press_state_e5", BTN_STATE_OFF, 32'h00);
        chk_rd("press_pend_e5",  BTN_PEND_OFF,  32'h00);
        tick(1);
        chk_rd("press_state_e6", BTN_STATE_OFF, 32'h04);
        chk_rd("press_pend_e6",  BTN_PEND_OFF,  32'h04);
        wr(BTN_PEND_OFF, 32'h04);
        chk_rd("press_pend_clr", BTN_PEND_OFF, 32'h00);

        // 3. bounce on button 1: high 3, low 1, high 3, low
        begin
            logic [6:0] pat;
            pat = 7'b1110111;
            for (int k = 6; k >= 0; k--) begin
                button = {3'b001, pat[k], 1'b0};
                tick(1);
                chk_rd("bounce_state", BTN_STATE_OFF, 32'h04);
                chk_rd("bounce_pend",  BTN_PEND_OFF,  32'h00);
            end
            button = 5'h04;
            for (int k = 0; k < 8; k++) begin
                tick(1);
                chk_rd("bounce_state_after", BTN_STATE_OFF, 32'h04);
                chk_rd("bounce_pend_after",  BTN_PEND_OFF,  32'h00);
            end
        end

        // 4. interrupt and clear
        wr(BTN_MASK_OFF, 32'h04);
        chk_rd("mask_rd", BTN_MASK_OFF, 32'h04);
        chk("irq_idle", {31'h0, irq}, 32'h0);
        button = 5'h00;
        tick(8);
        chk_rd("release_no_pend", BTN_PEND_OFF, 32'h00);
        chk("irq_release", {31'h0, irq}, 32'h0);
        button = 5'h04;
        tick(5);
        chk("irq_e5", {31'h0, irq}, 32'h0);
        tick(1);
        chk("irq_e6", {31'h0, irq}, 32'h1);
        chk_rd("irq_pend", BTN_PEND_OFF, 32'h04);
        wr(BTN_PEND_OFF, 32'h00);
        chk_rd("w1c_zero_pend", BTN_PEND_OFF, 32'h04);
        chk("w1c_zero_irq", {31'h0, irq}, 32'h1);
        wr(BTN_PEND_OFF, 32'h04);
        chk_rd("w1c_pend", BTN_PEND_OFF, 32'h00);
        chk("w1c_irq", {31'h0, irq}, 32'h0);

        // 5. set and clear on the same edge
        button = 5'h06;
        tick(6);
        chk_rd("pend1_set", BTN_PEND_OFF, 32'h02);
        button = 5'h07;
        tick(5);
        wr(BTN_PEND_OFF, 32'h03);
        chk_rd("setclr_pend",  BTN_PEND_OFF,  32'h01);
        chk_rd("setclr_state", BTN_STATE_OFF, 32'h07);
        chk("setclr_irq", {31'h0, irq}, 32'h0);

        // 6. bus decode
        wr(BTN_STATE_OFF, 32'hFFFF_FFFF);
        chk_rd("ro_state", BTN_STATE_OFF, 32'h07);
        wr(12'h090, 32'hFFFF_FFFF);
        chk_rd("unmapped_pend", BTN_PEND_OFF, 32'h01);
        chk_rd("unmapped_mask", BTN_MASK_OFF, 32'h04);
        chk_rd("rd_084", 12'h084, 32'h0);
        chk_rd("rd_090", 12'h090, 32'h0);
        wr(BTN_MASK_OFF, 32'hFFFF_FFFF);
        chk_rd("mask_all", BTN_MASK_OFF, 32'h1F);
        chk("irq_mask_all", {31'h0, irq}, 32'h1);

        // asynchronous reset mid-debounce
        button = 5'h18;
        tick(3);
        #2;
        rst = 1'b0;
        #1;
        chk_rd("arst_state", BTN_STATE_OFF, 32'h0);
        chk_rd("arst_pend",  BTN_PEND_OFF,  32'h0);
        chk_rd("arst_mask",  BTN_MASK_OFF,  32'h0);
        chk("arst_irq", {31'h0, irq}, 32'h0);
        tick(2);
        rst = 1'b1;
        tick(5);
        chk_rd("arst_resume_e5", BTN_STATE_OFF, 32'h00);
        tick(1);
        chk_rd("arst_resume_e6", BTN_STATE_OFF, 32'h18);
        chk_rd("arst_resume_pend", BTN_PEND_OFF, 32'h18);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
